// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle for the IF/ID queue; the queue takes the slave view,
// the fetch/decode environment the master view.
interface if_id_queue_if;
  logic [15:0] instr_in;
  logic [15:0] pc_next_in;
  logic        instr_valid_in;
  logic        stall_in;
  logic        flush_in;
  logic [15:0] instr_out;
  logic [15:0] pc_next_out;
  logic        valid_out;
  logic        full_out;
  logic [1:0]  count_out;
  logic        halted_out;

  modport master (
    output instr_in, pc_next_in, instr_valid_in, stall_in, flush_in,
    input  instr_out, pc_next_out, valid_out, full_out, count_out, halted_out
  );

  modport slave (
    input  instr_in, pc_next_in, instr_valid_in, stall_in, flush_in,
    output instr_out, pc_next_out, valid_out, full_out, count_out, halted_out
  );
endinterface

// File: rtl/if_id_queue.sv
// 2-entry IF/ID FIFO: a push into an empty queue shows on instr_out next cycle; pushes while
// full or halted are dropped (fetch holds on full_out), stall_in holds the head, flush_in clears all.
module if_id_queue #(
  parameter logic [15:0] NOP_INSTR   = 16'h0800,
  parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
  input  logic         clk,
  input  logic         rst,
  if_id_queue_if.slave q
);

  logic [15:0] instr_mem [2];
  logic [15:0] pc_mem    [2];

  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q,  count_d;
  logic       halted_q, halted_d;

  logic full, valid, push, pop;

  assign full  = (count_q == 2'd2);
  assign valid = (count_q != 2'd0);
  assign push  = q.instr_valid_in & ~full & ~halted_q & ~q.flush_in;
  assign pop   = valid & ~q.stall_in & ~q.flush_in;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    halted_d = halted_q;
    if (q.flush_in) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
      halted_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
      // The HALT word itself is queued; only later pushes are blocked.
      if (push && (q.instr_in[15:11] == HALT_OPCODE)) halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      halted_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= q.instr_in;
      pc_mem[wr_ptr_q]    <= q.pc_next_in;
    end
  end

  // Outputs depend only on registered state, so they follow rst immediately.
  assign q.valid_out   = valid;
  assign q.full_out    = full;
  assign q.count_out   = count_q;
  assign q.halted_out  = halted_q;
  assign q.instr_out   = valid ? instr_mem[rd_ptr_q] : NOP_INSTR;
  assign q.pc_next_out = valid ? pc_mem[rd_ptr_q]    : 16'h0000;

endmodule
